alu_unit: RTL and testbench
===========================

// Module: alu_unit
// PURPOSE
//  32-bit integer ALU for the single-cycle/multicycle CPU datapath: logic, add/sub, set-less-than, shift.
//  Result F and five status flags (ZF OF SF CF PF) are registered; one-cycle latency.
//  Sits between register-file read ports and writeback/branch logic.
// PARAMETERS
//  WIDTH  32  datapath width (flags/shift rules below written for 32; shamt width = $clog2(WIDTH))
// PORTS
//  clk     in   1   single clock; all state updates on rising edge
//  rst_n   in   1   reset, synchronous, active-low
//  ALU_OP  in   4   operation select
//  A       in   32  operand A (also shift amount source)
//  B       in   32  operand B (shifted operand)
//  F       out  32  result
//  ZF      out  1   zero flag
//  OF      out  1   signed overflow flag
//  SF      out  1   sign flag
//  CF      out  1   carry/borrow flag
//  PF      out  1   parity flag
// BEHAVIOUR
//  - Reset: rst_n==0 at posedge -> F=0, ZF=0, OF=0, SF=0, CF=0, PF=0. Reset dominates any op in same cycle.
//  - Latency 1: inputs sampled at posedge N, F/flags valid after posedge N; no handshake, new op every cycle.
//  - Ops: 0000 AND A&B; 0001 OR A|B; 0010 XOR A^B; 0011 NOR ~(A|B);
//    0100 ADD A+B; 0101 SUB A-B; 0110 SLT F=($signed(A)<$signed(B)) zero-extended; 0111 SLL F=B<<A[4:0].
//  - 1000-1111 without ext macro: F=0 (so ZF=1, PF=1, others 0).
//  - ADD: 33-bit sum; CF=carry out bit32; OF=(A[31]==B[31])&&(F[31]!=A[31]).
//  - SUB: computed as A+~B+1; CF=borrow=1 iff A<B unsigned; OF=(A[31]!=B[31])&&(F[31]!=A[31]).
//  - CF=0 and OF=0 for every op other than ADD/SUB.
//  - ZF=(F==0); SF=F[31]; PF=~^F (1 when F has an even count of ones, incl. F=0); all from the registered F.
//  - Wrap-around: ADD/SUB results modulo 2^32; shift amounts use only A[4:0] (A=32 -> shift 0).
// CONFIGURATION
//  ALU_EXT_OPS_EN defined: 1000 SRL F=B>>A[4:0]; 1001 SRA F=$signed(B)>>>A[4:0];
//    1010 SLTU F=(A<B unsigned); 1011-1111 F=0. CF/OF=0 for these ops.
//  ALU_EXT_OPS_EN undefined: 1000-1111 all give F=0 as above.
// STRUCTURE
//  Package alu_pkg: WIDTH constant, op-code localparams/enum (OP_AND..OP_SLL, OP_SRL, OP_SRA, OP_SLTU).
//  Sub-module alu_addsub: shared 33-bit adder (sub via invert+carry-in), outputs sum, carry, overflow;
//    SLT/SLTU reuse its subtract result. Top: combinational op mux + flag logic + output register.
// TESTING
//  A=12345678 B=9ABCDEF0 ADD -> F=ACF13568, SF=1, CF=0, OF=0, ZF=0.
//  A=FFFFFFFF B=00000001: ADD -> F=0, ZF=1, CF=1, OF=0; SUB -> F=FFFFFFFE, CF=0; SLT -> F=1.
//  A=88888888 B=88888888: ADD -> F=11111110, CF=1, OF=1; SUB -> F=0, ZF=1, CF=0, OF=0.
//  A=F0F0F0F0 B=0F0F0F0F: AND -> F=0, ZF=1, PF=1; OR -> F=FFFFFFFF, SF=1, PF=1.
//  A=0001FFFF B=FFFF0001: SLL -> F=80000000 (shift 31); SLT -> F=0; NOR -> F=0000FFFE? no: F=~FFFFFFFF=0, ZF=1.
//  Assert rst_n=0 while ALU_OP=ADD active -> next edge all outputs 0; release -> result one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, op-code encoding and flag bundle for the 32-bit ALU.
// Extended shift/compare op-codes are only decoded when ALU_EXT_OPS_EN is defined.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_NOR  = 4'b0011,
    OP_ADD  = 4'b0100,
    OP_SUB  = 4'b0101,
    OP_SLT  = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_SLTU = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic zf;
    logic of;
    logic sf;
    logic cf;
    logic pf;
  } alu_flags_t;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: subtraction is done as a + ~b + 1.
// Purely combinational. There is no handshake and no backpressure.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign full  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};

  assign sum_o   = full[WIDTH-1:0];
  assign carry_o = full[WIDTH];
  // Operands of the same effective sign that produce a result of the other sign
  assign ovf_o   = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/alu_unit.sv
// 32-bit ALU with registered result and ZF/OF/SF/CF/PF. Latency is one cycle, and a new op is accepted every cycle.
// There is no backpressure. Defining ALU_EXT_OPS_EN enables SRL/SRA/SLTU.
module alu_unit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ALU_OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF,
  output logic             SF,
  output logic             CF,
  output logic             PF
);

  alu_op_e          op;
  logic [SHAMT_W-1:0] shamt;
  logic             as_sub;
  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_ovf;

  logic [WIDTH-1:0] f_d, f_q;
  logic             cf_d, of_d;
  alu_flags_t       flags_d, flags_q;

  assign op     = alu_op_e'(ALU_OP);
  assign shamt  = A[SHAMT_W-1:0];
  assign as_sub = (op != OP_ADD);

  alu_addsub u_addsub (
    .a_i     (A),
    .b_i     (B),
    .sub_i   (as_sub),
    .sum_o   (as_sum),
    .carry_o (as_carry),
    .ovf_o   (as_ovf)
  );

  always_comb begin
    f_d  = '0;
    cf_d = 1'b0;
    of_d = 1'b0;
    case (op)
      OP_AND: f_d = A & B;
      OP_OR:  f_d = A | B;
      OP_XOR: f_d = A ^ B;
      OP_NOR: f_d = ~(A | B);
      OP_ADD: begin
        f_d  = as_sum;
        cf_d = as_carry;
        of_d = as_ovf;
      end
      OP_SUB: begin
        f_d  = as_sum;
        cf_d = ~as_carry;
        of_d = as_ovf;
      end
      // Signed less-than: the sign of the true difference is sum sign corrected by overflow
      OP_SLT: f_d = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      OP_SLL: f_d = B << shamt;
`ifdef ALU_EXT_OPS_EN
      OP_SRL:  f_d = B >> shamt;
      OP_SRA:  f_d = $unsigned($signed(B) >>> shamt);
      OP_SLTU: f_d = {{(WIDTH-1){1'b0}}, ~as_carry};
`endif
      default: f_d = '0;
    endcase
  end

  always_comb begin
    flags_d    = '0;
    flags_d.zf = (f_d == '0);
    flags_d.of = of_d;
    flags_d.sf = f_d[WIDTH-1];
    flags_d.cf = cf_d;
    flags_d.pf = ~^f_d;
  end

  // Flags are registered separately from F so that reset can clear ZF/PF as well
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q     <= '0;
      flags_q <= '0;
    end else begin
      f_q     <= f_d;
      flags_q <= flags_d;
    end
  end

  assign F  = f_q;
  assign ZF = flags_q.zf;
  assign OF = flags_q.of;
  assign SF = flags_q.sf;
  assign CF = flags_q.cf;
  assign PF = flags_q.pf;

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: arithmetic reference model compared every cycle, plus literal checks on directed vectors.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ALU_OP;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] F;
  logic        ZF, OF, SF, CF, PF;

  int errors = 0;
  int checks = 0;

  alu_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ALU_OP (ALU_OP),
    .A      (A),
    .B      (B),
    .F      (F),
    .ZF     (ZF),
    .OF     (OF),
    .SF     (SF),
    .CF     (CF),
    .PF     (PF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {F, ZF, OF, SF, CF, PF}
  function automatic logic [36:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] f;
    logic        cf, of;
    longint      sa, sb, r;
    logic [32:0] wide;
    f  = 32'd0;
    cf = 1'b0;
    of = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: f = a & b;
      4'd1: f = a | b;
      4'd2: f = a ^ b;
      4'd3: f = ~(a | b);
      4'd4: begin
        wide = {1'b0, a} + {1'b0, b};
        f  = wide[31:0];
        cf = wide[32];
        r  = sa + sb;
        of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd5: begin
        f  = a - b;
        cf = (a < b);
        r  = sa - sb;
        of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd6: f = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: f = b << (a % 32);
`ifdef ALU_EXT_OPS_EN
      4'd8:  f = b >> (a % 32);
      4'd9:  f = $unsigned($signed(b) >>> (a % 32));
      4'd10: f = (a < b) ? 32'd1 : 32'd0;
`endif
      default: f = 32'd0;
    endcase
    model = {f, (f == 32'd0), of, f[31], cf, ($countones(f) % 2 == 0)};
  endfunction

  logic [36:0] exp_q;
  logic        started = 1'b0;

  always @(posedge clk) begin
    exp_q   <= rst_n ? model(ALU_OP, A, B) : 37'd0;
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({F, ZF, OF, SF, CF, PF} !== exp_q) begin
        errors++;
        $display("FAIL model_cmp t=%0t op=%h A=%h B=%h got=%h exp=%h", $time, ALU_OP, A, B,
                 {F, ZF, OF, SF, CF, PF}, exp_q);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALU_OP = op;
    A      = a;
    B      = b;
    @(posedge clk);
    #1;
  endtask

  // Flags packed as {ZF,OF,SF,CF,PF}
  task automatic vec(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] f_exp, input logic [4:0] fl_exp);
    run(op, a, b);
    chk({name, "_f"}, F, f_exp);
    chk({name, "_flags"}, {27'd0, ZF, OF, SF, CF, PF}, {27'd0, fl_exp});
  endtask

  logic [31:0] va [8];

  initial begin
    rst_n  = 1'b0;
    ALU_OP = 4'd4;
    A      = 32'h1234_5678;
    B      = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_f", F, 32'd0);
    chk("reset_flags", {27'd0, ZF, OF, SF, CF, PF}, 32'd0);
    rst_n = 1'b1;

    vec("add1",  4'd4, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 5'b00101);
    vec("add2",  4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 5'b10011);
    vec("sub2",  4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 5'b00100);
    vec("slt2",  4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 5'b00000);
    vec("add3",  4'd4, 32'h8888_8888, 32'h8888_8888, 32'h1111_1110, 5'b01010);
    vec("sub3",  4'd5, 32'h8888_8888, 32'h8888_8888, 32'h0000_0000, 5'b10001);
    vec("and4",  4'd0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 5'b10001);
    vec("or4",   4'd1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 5'b00101);
    vec("sll5",  4'd7, 32'h0001_FFFF, 32'hFFFF_0001, 32'h8000_0000, 5'b00100);
    vec("slt5",  4'd6, 32'h0001_FFFF, 32'hFFFF_0001, 32'h0000_0000, 5'b10001);
    vec("nor5",  4'd3, 32'h0001_FFFF, 32'hFFFF_0001, 32'h0000_0000, 5'b10001);
    vec("sll32", 4'd7, 32'h0000_0020, 32'h0000_00F0, 32'h0000_00F0, 5'b00001);
    vec("op11",  4'd11, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 5'b10001);
    vec("sub_ov", 4'd5, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 5'b01000);
`ifdef ALU_EXT_OPS_EN
    vec("sra",   4'd9, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 5'b00100);
`else
    vec("op8",   4'd8, 32'h0000_0004, 32'h8000_0000, 32'h0000_0000, 5'b10001);
`endif

    // Reset dominates an ADD in the same cycle; the op resumes one cycle after release
    rst_n = 1'b0;
    run(4'd4, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("rst_add_f", F, 32'd0);
    chk("rst_add_flags", {27'd0, ZF, OF, SF, CF, PF}, 32'd0);
    rst_n = 1'b1;
    run(4'd4, 32'hFFFF_FFFF, 32'h0000_0001);
    chk("rel_add_flags", {27'd0, ZF, OF, SF, CF, PF}, 32'h0000_0013);

    va[0] = 32'h0000_0000; va[1] = 32'hFFFF_FFFF; va[2] = 32'h7FFF_FFFF; va[3] = 32'h8000_0000;
    va[4] = 32'h0000_0021; va[5] = 32'hDEAD_BEEF; va[6] = 32'h0000_001F; va[7] = 32'h1357_9BDF;
    for (int op = 0; op < 16; op++)
      for (int i = 0; i < 8; i++)
        run(op[3:0], va[i], va[(i * 3 + 1) % 8]);
    for (int k = 0; k < 200; k++)
      run(4'($urandom_range(0, 15)), $urandom, $urandom);

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
